// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcode/funct codes, FSM states
// and datapath mux selects, plus the DECODE dispatch function.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_DIV  = 6'b011010;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MFLO = 6'b010010;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        R_WB     = 4'd3,
        EXEC_I   = 4'd4,
        I_WB     = 4'd5,
        MEM_ADR  = 4'd6,
        MEM_RD   = 4'd7,
        MEM_WB   = 4'd8,
        MEM_WR   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        MD_START = 4'd12,
        MD_BUSY  = 4'd13,
        HILO_WB  = 4'd14
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_HI     = 2'b10;
    localparam logic [1:0] M2R_LO     = 2'b11;

    // FETCH as the result means the instruction is not decodable.
    function automatic state_t decodeNext(input logic [5:0] op, input logic [5:0] fn);
        state_t nxt;
        nxt = FETCH;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    F_AND, F_OR, F_NOR, F_ADD, F_SUB, F_SLT: nxt = EXEC_R;
                    F_MULT, F_DIV:                           nxt = MD_START;
                    F_MFHI, F_MFLO:                          nxt = HILO_WB;
                    default:                                 nxt = FETCH;
                endcase
            end
            OP_LW, OP_SW: nxt = MEM_ADR;
            OP_ADDI:      nxt = EXEC_I;
            OP_BEQ:       nxt = BRANCH;
            OP_J:         nxt = JUMP;
            default:      nxt = FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mips_md_counter.sv
// Mult/div busy down-counter: load N-1, decrement to zero, done while at zero.
// Latency: done is valid the cycle after load when loadVal is 0.
// Backpressure: none; decrements whenever dec is high and count is nonzero.
module mips_md_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] loadVal,
    input  logic             dec,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM driving the shared-memory datapath, incl. mult/div and HI/LO.
// Latency: 3-5 cycles per instruction (mult/div 3+N), plus one per memory wait cycle.
// Backpressure: FETCH, MEM_RD and MEM_WR hold while mem_ready is low (when enabled).
module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter int MULT_CYCLES   = 4,
    parameter int DIV_CYCLES    = 32,
    parameter int USE_MEM_READY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       md_start,
    output logic       md_op,
    output logic       HiLoWrite,
    output logic       illegal,
    output logic [3:0] state_o
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_t     state;
    state_t     decNext;
    logic [5:0] opLat;
    logic [5:0] fnLat;
    logic       rdy;
    logic       isDiv;
    logic       mdDone;

    logic pcWr, pcWrCond, irWr, memWr, regWr, hiLoWr, mdStart, illegalInt;

    assign rdy     = (USE_MEM_READY != 0) ? mem_ready : 1'b1;
    assign decNext = decodeNext(opcode, funct);
    assign isDiv   = (fnLat == F_DIV);

    mips_md_counter #(.WIDTH(CNT_W)) u_mdCounter (
        .clk     (clk),
        .rst     (rst),
        .load    (state == MD_START),
        .loadVal (isDiv ? DIV_LOAD : MULT_LOAD),
        .dec     (state == MD_BUSY),
        .done    (mdDone)
    );

    // opcode/funct are captured in DECODE so later states ignore IR changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            opLat <= '0;
            fnLat <= '0;
        end else begin
            case (state)
                FETCH:    if (rdy) state <= DECODE;
                DECODE: begin
                    opLat <= opcode;
                    fnLat <= funct;
                    state <= decNext;
                end
                EXEC_R:   state <= R_WB;
                EXEC_I:   state <= I_WB;
                MEM_ADR:  state <= (opLat == OP_SW) ? MEM_WR : MEM_RD;
                MEM_RD:   if (rdy) state <= MEM_WB;
                MEM_WR:   if (rdy) state <= FETCH;
                MD_START: state <= MD_BUSY;
                MD_BUSY:  if (mdDone) state <= FETCH;
                default:  state <= FETCH;
            endcase
        end
    end

    always_comb begin
        pcWr       = 1'b0;
        pcWrCond   = 1'b0;
        irWr       = 1'b0;
        memWr      = 1'b0;
        regWr      = 1'b0;
        hiLoWr     = 1'b0;
        mdStart    = 1'b0;
        illegalInt = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemtoReg   = M2R_ALUOUT;
        RegDst     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_B;
        ALUOp      = ALUOP_ADD;
        PCSource   = PCSRC_ALU;
        md_op      = 1'b0;
        case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                irWr    = rdy;
                pcWr    = rdy;
            end
            DECODE: begin
                ALUSrcB    = SRCB_IMMSH;
                illegalInt = (decNext == FETCH);
            end
            EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            R_WB: begin
                regWr  = 1'b1;
                RegDst = 1'b1;
            end
            EXEC_I, MEM_ADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            I_WB:   regWr = 1'b1;
            MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEM_WB: begin
                regWr    = 1'b1;
                MemtoReg = M2R_MDR;
            end
            MEM_WR: begin
                IorD  = 1'b1;
                memWr = rdy;
            end
            BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = ALUOP_SUB;
                pcWrCond = 1'b1;
                PCSource = PCSRC_ALUOUT;
            end
            JUMP: begin
                pcWr     = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            MD_START: begin
                mdStart = 1'b1;
                md_op   = isDiv;
            end
            MD_BUSY: hiLoWr = mdDone;
            HILO_WB: begin
                regWr    = 1'b1;
                RegDst   = 1'b1;
                MemtoReg = (fnLat == F_MFHI) ? M2R_HI : M2R_LO;
            end
            default: ;
        endcase
    end

    // Reset aborts immediately: no strobe may leak out while rst is high.
    assign PCWrite     = pcWr       & ~rst;
    assign PCWriteCond = pcWrCond   & ~rst;
    assign IRWrite     = irWr       & ~rst;
    assign MemWrite    = memWr      & ~rst;
    assign RegWrite    = regWr      & ~rst;
    assign HiLoWrite   = hiLoWr     & ~rst;
    assign md_start    = mdStart    & ~rst;
    assign illegal     = illegalInt & ~rst;
    assign state_o     = state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed-vector bench for mips_multicycle_control: per-cycle state and strobe checks.
module tb_mips_multicycle_control;
    import mips_pkg::*;

    // Strobe vector: {PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite, HiLoWrite, md_start, illegal}
    localparam logic [8:0] S_NONE  = 9'b000000000;
    localparam logic [8:0] S_FETCH = 9'b101100000;
    localparam logic [8:0] S_MRD   = 9'b000100000;
    localparam logic [8:0] S_MWR   = 9'b000010000;
    localparam logic [8:0] S_REGW  = 9'b000001000;
    localparam logic [8:0] S_HILO  = 9'b000000100;
    localparam logic [8:0] S_MDST  = 9'b000000010;
    localparam logic [8:0] S_ILL   = 9'b000000001;
    localparam logic [8:0] S_BR    = 9'b010000000;
    localparam logic [8:0] S_J     = 9'b100000000;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic [1:0] MemtoReg;
    logic       RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       md_start, md_op, HiLoWrite, illegal;
    logic [3:0] state_o;

    int nCmp = 0;
    int nBad = 0;

    always #5 clk = ~clk;

    mips_multicycle_control #(
        .MULT_CYCLES   (4),
        .DIV_CYCLES    (32),
        .USE_MEM_READY (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct       (funct),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .md_start    (md_start),
        .md_op       (md_op),
        .HiLoWrite   (HiLoWrite),
        .illegal     (illegal),
        .state_o     (state_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic look(input string tag, input logic [3:0] st, input logic [8:0] strb);
        #1;
        chk({tag, ".state"}, 32'(state_o), 32'(st));
        chk({tag, ".strobes"},
            32'({PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite, HiLoWrite, md_start, illegal}),
            32'(strb));
    endtask

    task automatic adv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b1;
        opcode    = 6'd0;
        funct     = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        look("reset", FETCH, S_MRD);
        chk("reset.srcb", 32'(ALUSrcB), 32'd1);
        rst = 1'b0;

        // add: 4 cycles, write-back only in the last one
        opcode = OP_RTYPE; funct = F_ADD;
        look("add.c1", FETCH, S_FETCH); adv;
        look("add.c2", DECODE, S_NONE);
        chk("add.c2.srcb", 32'(ALUSrcB), 32'd3); adv;
        look("add.c3", EXEC_R, S_NONE);
        chk("add.c3.aluop", 32'(ALUOp), 32'd2);
        chk("add.c3.srca", 32'(ALUSrcA), 32'd1); adv;
        look("add.c4", R_WB, S_REGW);
        chk("add.c4.regdst", 32'(RegDst), 32'd1);
        chk("add.c4.m2r", 32'(MemtoReg), 32'd0); adv;

        // lw with two wait cycles; IR changes to sw after DECODE must not matter
        opcode = OP_LW;
        look("lw.c1", FETCH, S_FETCH); adv;
        look("lw.c2", DECODE, S_NONE); adv;
        opcode = OP_SW;
        look("lw.c3", MEM_ADR, S_NONE);
        chk("lw.c3.srcb", 32'(ALUSrcB), 32'd2); adv;
        mem_ready = 1'b0;
        look("lw.wait1", MEM_RD, S_MRD);
        chk("lw.wait1.iord", 32'(IorD), 32'd1); adv;
        look("lw.wait2", MEM_RD, S_MRD); adv;
        mem_ready = 1'b1;
        look("lw.rd", MEM_RD, S_MRD); adv;
        look("lw.wb", MEM_WB, S_REGW);
        chk("lw.wb.m2r", 32'(MemtoReg), 32'd1);
        chk("lw.wb.regdst", 32'(RegDst), 32'd0); adv;

        // sw with a FETCH wait and a write wait
        opcode = OP_SW; mem_ready = 1'b0;
        look("sw.fwait", FETCH, S_MRD); adv;
        mem_ready = 1'b1;
        look("sw.c1", FETCH, S_FETCH); adv;
        look("sw.c2", DECODE, S_NONE); adv;
        look("sw.c3", MEM_ADR, S_NONE); adv;
        mem_ready = 1'b0;
        look("sw.wwait", MEM_WR, S_NONE);
        chk("sw.wwait.iord", 32'(IorD), 32'd1); adv;
        mem_ready = 1'b1;
        look("sw.wr", MEM_WR, S_MWR); adv;

        // mult (4 busy cycles), funct churn to div after DECODE, then mflo
        opcode = OP_RTYPE; funct = F_MULT;
        look("mult.c1", FETCH, S_FETCH); adv;
        look("mult.c2", DECODE, S_NONE); adv;
        funct = F_DIV;
        look("mult.c3", MD_START, S_MDST);
        chk("mult.c3.mdop", 32'(md_op), 32'd0); adv;
        for (int i = 0; i < 3; i++) begin
            look("mult.busy", MD_BUSY, S_NONE); adv;
        end
        look("mult.c7", MD_BUSY, S_HILO); adv;
        funct = F_MFLO;
        look("mflo.c1", FETCH, S_FETCH); adv;
        look("mflo.c2", DECODE, S_NONE); adv;
        look("mflo.c3", HILO_WB, S_REGW);
        chk("mflo.m2r", 32'(MemtoReg), 32'd3);
        chk("mflo.regdst", 32'(RegDst), 32'd1); adv;

        funct = F_MFHI;
        look("mfhi.c1", FETCH, S_FETCH); adv;
        look("mfhi.c2", DECODE, S_NONE); adv;
        look("mfhi.c3", HILO_WB, S_REGW);
        chk("mfhi.m2r", 32'(MemtoReg), 32'd2); adv;

        // illegal opcode and illegal R-type funct
        opcode = 6'b111111;
        look("ill.c1", FETCH, S_FETCH); adv;
        look("ill.c2", DECODE, S_ILL); adv;
        opcode = OP_RTYPE; funct = 6'b000001;
        look("illf.c1", FETCH, S_FETCH); adv;
        look("illf.c2", DECODE, S_ILL); adv;

        // beq
        opcode = OP_BEQ;
        look("beq.c1", FETCH, S_FETCH); adv;
        look("beq.c2", DECODE, S_NONE); adv;
        look("beq.c3", BRANCH, S_BR);
        chk("beq.pcsrc", 32'(PCSource), 32'd1);
        chk("beq.aluop", 32'(ALUOp), 32'd1); adv;

        // j
        opcode = OP_J;
        look("j.c1", FETCH, S_FETCH); adv;
        look("j.c2", DECODE, S_NONE); adv;
        look("j.c3", JUMP, S_J);
        chk("j.pcsrc", 32'(PCSource), 32'd2); adv;

        // addi
        opcode = OP_ADDI;
        look("addi.c1", FETCH, S_FETCH); adv;
        look("addi.c2", DECODE, S_NONE); adv;
        look("addi.c3", EXEC_I, S_NONE);
        chk("addi.srcb", 32'(ALUSrcB), 32'd2); adv;
        look("addi.c4", I_WB, S_REGW);
        chk("addi.regdst", 32'(RegDst), 32'd0); adv;

        // div aborted by reset in its 10th busy cycle
        opcode = OP_RTYPE; funct = F_DIV;
        look("div.c1", FETCH, S_FETCH); adv;
        look("div.c2", DECODE, S_NONE); adv;
        look("div.c3", MD_START, S_MDST);
        chk("div.mdop", 32'(md_op), 32'd1); adv;
        for (int i = 0; i < 9; i++) begin
            look("div.busy", MD_BUSY, S_NONE); adv;
        end
        look("div.busy10", MD_BUSY, S_NONE);
        rst = 1'b1;
        look("div.abort", FETCH, S_MRD); adv;
        look("div.inrst", FETCH, S_MRD);
        rst = 1'b0;
        look("div.after", FETCH, S_FETCH);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multicycle successor to the single-cycle opcode decoder.
- FSM sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK for the MIPS subset:
  - R-type: and, or, nor, add, sub, slt, mult, div, mfhi, mflo
  - I-type and jump: addi, lw, sw, beq, j
- Adds features the decoder lacks: memory wait-state handshake, a multi-cycle mult/div busy counter with HI/LO write, and illegal-instruction detection.
- Drives the shared-memory datapath: PC, IR, MDR, A/B, ALUOut and HI/LO registers.

Parameters:
- MULT_CYCLES, 4, cycles spent in MD_BUSY for mult; must be >=1.
- DIV_CYCLES, 32, cycles spent in MD_BUSY for div; must be >=1.
- USE_MEM_READY, 1, when 1 memory states wait for mem_ready; when 0 mem_ready is ignored and treated as 1.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  IR[31:26]; sampled in DECODE.
- funct  in  6  IR[5:0]; sampled in DECODE.
- mem_ready  in  1  memory access completes this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if ALU zero.
- IorD  out  1  memory address: 0=PC, 1=ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  2  write-back data: 00 ALUOut, 01 MDR, 10 HI, 11 LO.
- RegDst  out  1  destination register: 0=rt, 1=rd.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A input: 0=PC, 1=A.
- ALUSrcB  out  2  ALU B input: 00 B, 01 const 4, 10 sign-extended imm, 11 sign-extended imm<<2.
- ALUOp  out  2  00 add, 01 sub, 10 decode by funct.
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- md_start  out  1  one-cycle start pulse to the mult/div unit.
- md_op  out  1  0=mult, 1=div; valid with md_start.
- HiLoWrite  out  1  latch mult/div result into HI/LO.
- illegal  out  1  one-cycle pulse on an undecodable instruction.
- state_o  out  4  current state, for debug.

Behaviour:
- State register has asynchronous reset to FETCH. Outputs are a combinational decode of state, except the mem_ready-qualified write enables noted below.
- While rst=1, all write/strobe outputs (PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite, HiLoWrite, md_start, illegal) are forced to 0. All other outputs take their FETCH values.
- Let rdy = (USE_MEM_READY ? mem_ready : 1).
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=rdy.
  - Transition: stay in FETCH while !rdy, else go to DECODE.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - Transition by opcode:
    - 000000 with funct in {and, or, nor, add, sub, slt} -> EXEC_R
    - funct mult / div -> MD_START
    - funct mfhi / mflo -> HILO_WB
    - lw / sw -> MEM_ADR
    - addi -> EXEC_I
    - beq -> BRANCH
    - j -> JUMP
    - anything else -> FETCH with illegal=1 for this cycle
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=00 -> FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> I_WB.
- I_WB: RegWrite=1, RegDst=0, MemtoReg=00 -> FETCH.
- MEM_ADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD:
  - Outputs: MemRead=1, IorD=1.
  - Transition: hold while !rdy, else MEM_WB.
- MEM_WB: RegWrite=1, RegDst=0, MemtoReg=01 -> FETCH.
- MEM_WR:
  - Outputs: IorD=1, MemWrite=rdy.
  - Transition: hold while !rdy, else FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
- JUMP: PCWrite=1, PCSource=10 -> FETCH.
- MD_START:
  - Outputs: md_start=1, md_op = funct==div.
  - Loads down-counter with (md_op ? DIV_CYCLES : MULT_CYCLES) - 1 -> MD_BUSY.
- MD_BUSY:
  - Counter decrements each cycle.
  - At count==0: HiLoWrite=1, then -> FETCH.
- HILO_WB: RegWrite=1, RegDst=1, MemtoReg = (mfhi ? 10 : 11) -> FETCH.
- Instruction latency with rdy always 1:
  - R-type, addi, sw: 4 cycles
  - lw: 5 cycles
  - beq, j, mfhi/mflo: 3 cycles
  - mult/div: 3 + N cycles, where N = MULT_CYCLES or DIV_CYCLES
  - Each !rdy cycle adds 1.
- Because mfhi/mflo cannot issue until MD_BUSY exits, there is no HI/LO hazard.
- Counter width is $clog2(max(MULT_CYCLES, DIV_CYCLES) + 1). N=1 means HiLoWrite is asserted in the first MD_BUSY cycle.
- opcode/funct are latched in DECODE into internal registers. Later states use the latched copies, so IR changes after DECODE are harmless.
- Reset mid-instruction (including MD_BUSY or a memory wait) aborts immediately: state=FETCH, counter=0, no write strobe is asserted.

Decomposition:
- Shared package mips_pkg holds:
  - opcode/funct localparams (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J, F_AND, ..., F_MULT=6'b011000, F_DIV=6'b011010, F_MFHI=6'b010000, F_MFLO=6'b010010)
  - state enum (4-bit)
  - ALUOp, ALUSrcB, PCSource and MemtoReg encodings
- One natural sub-module, mips_md_counter: load, decrement, done flag.

Test Plan:
- Reset held with mem_ready=1, then released -> all strobes 0 during reset; first cycle after release IRWrite=PCWrite=1, state_o=FETCH.
- add (op 0, funct 100000), rdy=1 -> states FETCH, DECODE, EXEC_R, R_WB; RegWrite=1 and RegDst=1 only in cycle 4.
- lw with mem_ready low 2 cycles in MEM_RD -> MEM_RD held 3 cycles; total 7 cycles; MemtoReg=01 at write-back.
- mult with MULT_CYCLES=4, then mflo -> md_start pulse in cycle 3, HiLoWrite in cycle 7, mflo writes with MemtoReg=11 3 cycles later.
- Opcode 111111 -> illegal=1 in DECODE cycle, next state FETCH, no RegWrite or MemWrite asserted.
- div with DIV_CYCLES=32, rst asserted in the 10th MD_BUSY cycle -> immediate FETCH, HiLoWrite never asserted.
